// File: rtl/divider_stream_ctrl.sv
// Stream controller for the iterative divider: pops operand pairs, runs one divide at a time,
// screens divide-by-zero locally and pushes {err, remainder, quotient} downstream with statistics.
module divider_stream_ctrl #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      in_empty,
  input  logic [DIVIDEND_WIDTH+DIVISOR_WIDTH-1:0]   in_dout,
  output logic                                      in_rd_en,
  output logic                                      div_start,
  output logic [DIVIDEND_WIDTH-1:0]                 div_numerator,
  output logic [DIVISOR_WIDTH-1:0]                  div_denominator,
  input  logic [DIVIDEND_WIDTH-1:0]                 div_quotient,
  input  logic [DIVISOR_WIDTH-1:0]                  div_remainder,
  input  logic                                      div_done,
  input  logic                                      out_full,
  output logic                                      out_wr_en,
  output logic [DIVISOR_WIDTH+DIVIDEND_WIDTH:0]     out_din,
  output logic                                      busy,
  output logic [CNT_WIDTH-1:0]                      ops_count,
  output logic [CNT_WIDTH-1:0]                      err_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

  state_t                    state;
  logic [DIVIDEND_WIDTH-1:0] quo_r;
  logic [DIVISOR_WIDTH-1:0]  rem_r;
  logic                      err_r;
  logic [DIVIDEND_WIDTH-1:0] in_dividend;
  logic [DIVISOR_WIDTH-1:0]  in_divisor;

  assign in_dividend = in_dout[DIVIDEND_WIDTH+DIVISOR_WIDTH-1:DIVISOR_WIDTH];
  assign in_divisor  = in_dout[DIVISOR_WIDTH-1:0];
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      in_rd_en        <= 1'b0;
      div_start       <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      quo_r           <= '0;
      rem_r           <= '0;
      err_r           <= 1'b0;
      out_wr_en       <= 1'b0;
      out_din         <= '0;
      ops_count       <= '0;
      err_count       <= '0;
    end else begin
      in_rd_en  <= 1'b0;
      div_start <= 1'b0;
      out_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!in_empty) begin
            // Strobes are registered: the pop and the start pulse land in the cycle after
            // the head entry is latched, so the FWFT head is consumed exactly once.
            in_rd_en        <= 1'b1;
            div_numerator   <= in_dividend;
            div_denominator <= in_divisor;
            if (in_divisor == '0) begin
              quo_r <= in_dividend[DIVIDEND_WIDTH-1] ? {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}}
                                                     : {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
              rem_r <= '0;
              err_r <= 1'b1;
              state <= S_WRITE;
            end else begin
              div_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // Divider results exist only in the done cycle.
          if (div_done) begin
            quo_r <= div_quotient;
            rem_r <= div_remainder;
            err_r <= 1'b0;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!out_full) begin
            out_wr_en <= 1'b1;
            out_din   <= {err_r, rem_r, quo_r};
            if (ops_count != '1) ops_count <= ops_count + CNT_WIDTH'(1);
            if (err_r && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_stream_ctrl.sv
// Directed bench for divider_stream_ctrl with FIFO/divider responders and an arithmetic result model.
module tb_divider_stream_ctrl;
  localparam int DW  = 32;
  localparam int VW  = 32;
  localparam int CW  = 16;
  localparam int LAT = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_empty = 1'b1;
  logic [DW+VW-1:0] in_dout = '0;
  logic            in_rd_en;
  logic            div_start;
  logic [DW-1:0]   div_numerator;
  logic [VW-1:0]   div_denominator;
  logic [DW-1:0]   div_quotient = 32'hDEADBEEF;
  logic [VW-1:0]   div_remainder = 32'hBADC0FFE;
  logic            div_done = 1'b0;
  logic            out_full = 1'b0;
  logic            out_wr_en;
  logic [VW+DW:0]  out_din;
  logic            busy;
  logic [CW-1:0]   ops_count;
  logic [CW-1:0]   err_count;

  divider_stream_ctrl #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
    .div_start(div_start), .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din), .busy(busy),
    .ops_count(ops_count), .err_count(err_count));

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [DW+VW-1:0] fifo_q[$];
  logic [VW+DW:0]   exp_q[$];
  logic [VW+DW:0]   all_out[$];
  int n_writes = 0, n_starts = 0, n_pops = 0;
  int model_ops = 0, model_err = 0;
  int div_cnt = 0;
  logic prev_done = 1'b0;
  logic [DW-1:0] held_n = '0;
  logic [VW-1:0] held_d = '0;
  logic [VW+DW:0] last_out = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Divider semantics: truncating quotient, remainder follows the dividend; x/0 saturates.
  function automatic logic [VW+DW:0] model_result(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int sa, sb, q, r;
    sa = a;
    sb = b;
    if (sb == 0) return {1'b1, 32'h0, (sa < 0) ? 32'h80000000 : 32'h7FFFFFFF};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, 32'(r), 32'(q)};
  endfunction

  task automatic refresh_in();
    in_empty = (fifo_q.size() == 0);
    in_dout  = in_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input int a, input int b);
    fifo_q.push_back({32'(a), 32'(b)});
    exp_q.push_back(model_result(32'(a), 32'(b)));
    refresh_in();
  endtask

  // Single compare process plus upstream FIFO and divider responders, all on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      div_cnt = 0;
      div_done = 1'b0;
      prev_done = 1'b0;
      model_ops = 0;
      model_err = 0;
    end else begin
      if (div_start) begin
        n_starts++;
        check("start_gap", {30'd0, div_done, prev_done}, 0);
        check("start_nonzero_div", (div_denominator == '0), 0);
        held_n = div_numerator;
        held_d = div_denominator;
      end else if (div_cnt > 0) begin
        check("hold_num", div_numerator, held_n);
        check("hold_den", div_denominator, held_d);
      end
      if (in_rd_en) begin
        n_pops++;
        check("pop_nonempty", (fifo_q.size() > 0), 1);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (out_wr_en) begin
        n_writes++;
        last_out = out_din;
        all_out.push_back(out_din);
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          logic [VW+DW:0] e;
          e = exp_q.pop_front();
          check("result", out_din, e);
          if (model_ops < 65535) model_ops++;
          if (e[VW+DW] && model_err < 65535) model_err++;
        end
      end
      check("ops_count", ops_count, model_ops);
      check("err_count", err_count, model_err);

      prev_done = div_done;
      if (div_done) begin
        div_done = 1'b0;
        div_quotient = 32'hDEADBEEF;
        div_remainder = 32'hBADC0FFE;
      end
      if (div_start) div_cnt = LAT;
      else if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          logic [VW+DW:0] r;
          r = model_result(held_n, held_d);
          div_done = 1'b1;
          div_quotient = r[DW-1:0];
          div_remainder = r[VW+DW-1:DW];
        end
      end
      refresh_in();
    end
  end

  task automatic wait_writes(input int target);
    for (int i = 0; i < 300 && n_writes < target; i++) @(negedge clock);
    check("write_timeout", (n_writes >= target), 1);
  endtask

  initial begin
    int s0, p0, w0, wr_seen;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_rd", in_rd_en, 0);
    check("rst_start", div_start, 0);
    check("rst_wr", out_wr_en, 0);
    check("rst_din", out_din, 0);
    check("rst_num", div_numerator, 0);
    check("rst_ops", ops_count, 0);
    check("rst_err", err_count, 0);
    reset = 1'b0;

    // 100/7
    @(negedge clock);
    s0 = n_starts;
    push(100, 7);
    wait_writes(1);
    check("q100_7", last_out, {1'b0, 32'd2, 32'd14});
    check("q100_7_starts", n_starts - s0, 1);
    @(negedge clock);
    check("q100_7_ops", ops_count, 1);

    // -100/7
    push(-100, 7);
    wait_writes(2);
    check("qm100_7", last_out, {1'b0, 32'hFFFFFFFE, 32'hFFFFFFF2});

    // divide by zero, both signs
    @(negedge clock);
    s0 = n_starts;
    push(5, 0);
    push(-5, 0);
    wait_writes(4);
    check("dz_pos", all_out[2], {1'b1, 32'h0, 32'h7FFFFFFF});
    check("dz_neg", all_out[3], {1'b1, 32'h0, 32'h80000000});
    check("dz_no_start", n_starts - s0, 0);
    @(negedge clock);
    check("dz_err_count", err_count, 2);
    check("dz_ops_count", ops_count, 4);

    // backpressure from the done cycle
    push(1000, 10);
    for (int i = 0; i < 50 && !div_done; i++) @(negedge clock);
    check("bp_done_seen", div_done, 1);
    out_full = 1'b1;
    push(21, 4);
    w0 = n_writes;
    p0 = n_pops;
    repeat (10) begin
      @(negedge clock);
      check("bp_no_wr", out_wr_en, 0);
      check("bp_busy", busy, 1);
      check("bp_din_hold", out_din, all_out[3]);
    end
    check("bp_no_pop", n_pops - p0, 0);
    out_full = 1'b0;
    wr_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (out_wr_en) wr_seen++;
    end
    check("bp_one_write", wr_seen, 1);
    check("bp_result", all_out[4], {1'b0, 32'd0, 32'd100});
    wait_writes(w0 + 2);
    check("bp_next", last_out, {1'b0, 32'd1, 32'd5});

    // back-to-back preload
    @(negedge clock);
    p0 = n_pops;
    push(50, 5);
    push(9, 2);
    push(7, 1);
    wait_writes(w0 + 5);
    check("b2b_0", all_out[6], {1'b0, 32'd0, 32'd10});
    check("b2b_1", all_out[7], {1'b0, 32'd1, 32'd4});
    check("b2b_2", all_out[8], {1'b0, 32'd0, 32'd7});
    check("b2b_pops", n_pops - p0, 3);

    // reset while the divider is running
    @(negedge clock);
    push(77, 3);
    for (int i = 0; i < 50 && div_cnt < 2; i++) @(negedge clock);
    check("rst_wait_reached", (div_cnt >= 2), 1);
    w0 = n_writes;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr", out_wr_en, 0);
    check("mid_rst_ops", ops_count, 0);
    check("mid_rst_err", err_count, 0);
    repeat (2) @(negedge clock);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_no_write", n_writes - w0, 0);
    push(20, 3);
    wait_writes(w0 + 1);
    check("post_rst", last_out, {1'b0, 32'd2, 32'd6});
    @(negedge clock);
    check("post_rst_ops", ops_count, 1);
    check("exp_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
